// File: rtl/nac_stream_writeback_pkg.sv
// rtl/nac_stream_writeback_pkg.sv - shared types and constants for the stream writeback block
// Purpose: FSM state encoding, AXI page / word size constants and a small min helper.
// Ports: none (package).
package nac_stream_writeback_pkg;

  typedef enum logic [1:0] {
    NAC_WB_IDLE   = 2'd0,
    NAC_WB_REQ    = 2'd1,
    NAC_WB_DATA   = 2'd2,
    NAC_WB_WAIT_B = 2'd3
  } wb_state_e;

  localparam int NAC_AXI_PAGE_BYTES = 4096;
  localparam int NAC_WORD_BYTES     = 4;

  function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/nac_stream_writeback_sync_fifo.sv
// rtl/nac_stream_writeback_sync_fifo.sv - synchronous FIFO with first-word fall-through head
// Purpose: generic result buffer (module nac_sync_fifo), shared with the read prefetcher.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        synchronous flush of all entries
//   push_i/wdata_i write side (ignored when full)
//   pop_i          remove head (ignored when empty)
//   rdata_o        current head word
//   full_o/empty_o/count_o occupancy
module nac_sync_fifo
  import nac_stream_writeback_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  assign wr_ptr_d = wr_ptr_q + AW'(push_ok);
  assign rd_ptr_d = rd_ptr_q + AW'(pop_ok);
  assign count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nac_stream_writeback.sv
// rtl/nac_stream_writeback.sv - buffers ALU result words and writes them to DRAM as bursts
// Purpose: FIFO the ALU result stream and drain it as AXI-style write bursts that never
//   cross a 4KB page; flush drains a partial tail and then raises done.
// Optional: NAC_WB_PERF_CNT_EN adds perf_bursts/perf_words/perf_stall saturating counters.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   enable, start_addr, flush  run control, destination base, tail drain request
//   done                       flush complete
//   stream_data/valid/ready    ALU result stream
//   mem_addr/len/req/grant     burst address channel (len is N-1)
//   mem_wdata/wvalid/wlast/wready  write data channel
//   mem_bvalid                 write response
module nac_stream_writeback
  import nac_stream_writeback_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] start_addr,
  input  logic        flush,
  output logic        done,
  input  logic [31:0] stream_data,
  input  logic        stream_valid,
  output logic        stream_ready,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_len,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  output logic        mem_wlast,
  input  logic        mem_wready,
  input  logic        mem_bvalid
`ifdef NAC_WB_PERF_CNT_EN
  ,
  output logic [31:0] perf_bursts,
  output logic [31:0] perf_words,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e   state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_len_q, mem_len_d;
  logic [8:0]  beats_left_q, beats_left_d;
  logic        abort_q, abort_d;
  logic        done_q, done_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_clear;
  logic [31:0]   fifo_head;
  logic          push, pop, go;
  logic [12:0]   cnt_w, cnt_next, words_left, size_cap, size_w;

  assign push = stream_valid & stream_ready;
  assign pop  = mem_wvalid & mem_wready;

  // abort_q marks an enable drop during an open burst: intake stays closed and the
  // buffered tail is discarded once the burst has retired.
  assign fifo_clear = (state_q == NAC_WB_IDLE) & (~enable | abort_q);

  nac_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (fifo_clear),
    .push_i  (push),
    .wdata_i (stream_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Burst size: capped by BURST_LEN, by the words left in the 4KB page and, while
  // flushing, by what is buffered so a partial tail can go out.
  assign cnt_w      = 13'(fifo_count);
  assign words_left = (13'(NAC_AXI_PAGE_BYTES) - {1'b0, cur_addr_q[11:0]}) / 13'(NAC_WORD_BYTES);
  assign size_cap   = min13(13'(BURST_LEN), words_left);
  assign size_w     = flush ? min13(size_cap, cnt_w) : size_cap;
  assign go         = enable & ~abort_q & (cnt_w != 13'd0) & (cnt_w >= size_w);
  assign cnt_next   = fifo_clear ? 13'd0 : (cnt_w + 13'(push) - 13'(pop));

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_len_d    = mem_len_q;
    beats_left_d = beats_left_q;
    abort_d      = abort_q;
    if ((state_q != NAC_WB_IDLE) && !enable) begin
      abort_d = 1'b1;
    end
    case (state_q)
      NAC_WB_IDLE: begin
        abort_d = 1'b0;
        if (!enable) begin
          cur_addr_d = start_addr;
        end else if (go) begin
          state_d      = NAC_WB_REQ;
          mem_addr_d   = cur_addr_q;
          mem_len_d    = 8'(size_w - 13'd1);
          beats_left_d = 9'(size_w);
        end
      end
      NAC_WB_REQ: begin
        if (mem_grant) begin
          // beats_left_q still equals the burst size here.
          cur_addr_d = cur_addr_q + 32'(beats_left_q) * 32'(NAC_WORD_BYTES);
          state_d    = NAC_WB_DATA;
        end
      end
      NAC_WB_DATA: begin
        if (pop) begin
          beats_left_d = beats_left_q - 9'd1;
          if (beats_left_q == 9'd1) begin
            state_d = NAC_WB_WAIT_B;
          end
        end
      end
      NAC_WB_WAIT_B: begin
        if (mem_bvalid) begin
          state_d = NAC_WB_IDLE;
        end
      end
      default: state_d = NAC_WB_IDLE;
    endcase
    // Registered from next-state so done rises the cycle after the final bvalid and
    // falls the cycle after a push or an enable drop.
    done_d = flush & enable & (state_d == NAC_WB_IDLE) & (cnt_next == 13'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NAC_WB_IDLE;
      cur_addr_q   <= '0;
      mem_addr_q   <= '0;
      mem_len_q    <= '0;
      beats_left_q <= '0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_len_q    <= mem_len_d;
      beats_left_q <= beats_left_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
    end
  end

  assign mem_req      = (state_q == NAC_WB_REQ);
  assign mem_wvalid   = (state_q == NAC_WB_DATA);
  assign mem_wlast    = mem_wvalid & (beats_left_q == 9'd1);
  assign mem_wdata    = mem_wvalid ? fifo_head : 32'd0;
  assign mem_addr     = mem_addr_q;
  assign mem_len      = mem_len_q;
  assign done         = done_q;
  assign stream_ready = enable & ~fifo_full & ~abort_q & ~rst;

`ifdef NAC_WB_PERF_CNT_EN
  logic [31:0] perf_bursts_q, perf_words_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bursts_q <= '0;
      perf_words_q  <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (mem_req && mem_grant && (perf_bursts_q != '1)) perf_bursts_q <= perf_bursts_q + 32'd1;
      if (pop && (perf_words_q != '1))                  perf_words_q  <= perf_words_q + 32'd1;
      if (stream_valid && !stream_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_bursts = perf_bursts_q;
  assign perf_words  = perf_words_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_nac_stream_writeback.sv
// tb/tb_nac_stream_writeback.sv - directed self-checking bench for nac_stream_writeback
module tb_nac_stream_writeback;

  logic        clk = 1'b0;
  logic        rst, enable, flush, stream_valid;
  logic [31:0] start_addr, stream_data;
  logic        mem_grant = 1'b0, mem_wready = 1'b0, mem_bvalid = 1'b0;
  logic        done, stream_ready, mem_req, mem_wvalid, mem_wlast;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_len;
`ifdef NAC_WB_PERF_CNT_EN
  logic [31:0] perf_bursts, perf_words, perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic gnt_en = 1'b0, stall_en = 1'b0;
  int   last_cnt = 0, b_seen = 0, stab_bad = 0;
  logic [31:0] b_addr[$];
  logic [7:0]  b_len[$];
  logic [31:0] w_data[$];
  logic        w_last[$];
  logic        p_wvalid = 1'b0, p_wready = 1'b0, p_wlast = 1'b0, p_req = 1'b0, p_grant = 1'b0;
  logic [31:0] p_wdata = '0, p_addr = '0;

  nac_stream_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .start_addr   (start_addr),
    .flush        (flush),
    .done         (done),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .mem_addr     (mem_addr),
    .mem_len      (mem_len),
    .mem_req      (mem_req),
    .mem_grant    (mem_grant),
    .mem_wdata    (mem_wdata),
    .mem_wvalid   (mem_wvalid),
    .mem_wlast    (mem_wlast),
    .mem_wready   (mem_wready),
    .mem_bvalid   (mem_bvalid)
`ifdef NAC_WB_PERF_CNT_EN
    ,
    .perf_bursts  (perf_bursts),
    .perf_words   (perf_words),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Arbiter model: level grant, optional random wready, one bvalid after each wlast.
  always @(posedge clk) begin
    #1;
    mem_grant  = gnt_en;
    mem_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (last_cnt != b_seen) begin
      mem_bvalid = 1'b1;
      b_seen     = last_cnt;
    end else begin
      mem_bvalid = 1'b0;
    end
  end

  // Bus monitor: records handshakes and flags any withdrawal or change while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (p_wvalid && !p_wready && !(mem_wvalid && mem_wdata == p_wdata && mem_wlast == p_wlast))
        stab_bad++;
      if (p_req && !p_grant && !(mem_req && mem_addr == p_addr))
        stab_bad++;
      if (mem_req && mem_grant) begin
        b_addr.push_back(mem_addr);
        b_len.push_back(mem_len);
      end
      if (mem_wvalid && mem_wready) begin
        w_data.push_back(mem_wdata);
        w_last.push_back(mem_wlast);
        if (mem_wlast) last_cnt++;
      end
    end
    p_wvalid = mem_wvalid & ~rst;
    p_wready = mem_wready;
    p_wlast  = mem_wlast;
    p_wdata  = mem_wdata;
    p_req    = mem_req & ~rst;
    p_grant  = mem_grant;
    p_addr   = mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int t = 0;
    stream_data  = d;
    stream_valid = 1'b1;
    @(negedge clk);
    while (!stream_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("push_timeout", 32'(stream_ready), 32'd1);
    @(posedge clk);
    #1;
    stream_valid = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) push_word(base + 32'(i));
  endtask

  task automatic wait_beats(input int n, input string tag);
    int t = 0;
    while (w_data.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(w_data.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    @(negedge clk);
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [31:0] addr, input logic [7:0] len);
    chk({tag, "_addr"}, (idx < b_addr.size()) ? b_addr[idx] : 32'hxxxx_xxxx, addr);
    chk({tag, "_len"}, (idx < b_len.size()) ? 32'(b_len[idx]) : 32'hxxxx_xxxx, 32'(len));
  endtask

  task automatic chk_data(input string tag, input int base, input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_data%0d", tag, i),
          ((base + i) < w_data.size()) ? w_data[base + i] : 32'hxxxx_xxxx, first + 32'(i));
  endtask

  task automatic restart(input logic [31:0] addr);
    enable     = 1'b0;
    start_addr = addr;
    tick(2);
    enable     = 1'b1;
  endtask

  int bb, wb;
  logic [31:0] mask;

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; stream_valid = 1'b0;
    stream_data = '0; start_addr = '0;
    tick(3);
    @(negedge clk);
    chk("rst_ready", 32'(stream_ready), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_wlast", 32'(mem_wlast), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_len", 32'(mem_len), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: aligned start, two full bursts, one-cycle request latency
    gnt_en = 1'b1;
    restart(32'h0000_1000);
    bb = b_addr.size(); wb = w_data.size();
    @(negedge clk);
    chk("t1_ready", 32'(stream_ready), 32'd1);
    @(posedge clk); #1;
    push_n(16, 32'h100);
    @(negedge clk);
    chk("t1_req_pre", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("t1_req_rise", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    push_n(16, 32'h110);
    wait_beats(wb + 32, "t1_beats");
    tick(4);
    chk("t1_nburst", 32'(b_addr.size() - bb), 32'd2);
    chk_burst("t1_b0", bb, 32'h1000, 8'd15);
    chk_burst("t1_b1", bb + 1, 32'h1040, 8'd15);
    chk_data("t1", wb, 32'h100, 32);
    mask = '0;
    for (int i = 0; i < 32; i++)
      if ((wb + i) < w_last.size() && w_last[wb + i]) mask[i] = 1'b1;
    chk("t1_wlast_mask", mask, 32'h8000_8000);

    // 2: page boundary split, tail drained by flush
    restart(32'h0000_1FF8);
    bb = b_addr.size(); wb = w_data.size();
    push_n(16, 32'h200);
    tick(4);
    chk("t2_one_burst", 32'(b_addr.size() - bb), 32'd1);
    flush = 1'b1;
    wait_beats(wb + 16, "t2_beats");
    wait_done("t2_done");
    chk("t2_nburst", 32'(b_addr.size() - bb), 32'd2);
    chk_burst("t2_b0", bb, 32'h1FF8, 8'd1);
    chk_burst("t2_b1", bb + 1, 32'h2000, 8'd13);
    chk_data("t2", wb, 32'h200, 16);
    flush = 1'b0;

    // 3: short tail via flush, done timing around bvalid, push and enable drop
    restart(32'h0000_0000);
    bb = b_addr.size(); wb = w_data.size();
    push_n(5, 32'h300);
    tick(3);
    @(negedge clk);
    chk("t3_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    begin
      int t = 0;
      @(negedge clk);
      while (!mem_bvalid && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("t3_bvalid_seen", 32'(mem_bvalid), 32'd1);
    end
    chk("t3_done_at_b", 32'(done), 32'd0);
    @(negedge clk);
    chk("t3_done_after_b", 32'(done), 32'd1);
    chk_burst("t3_b0", bb, 32'h0, 8'd4);
    chk_data("t3", wb, 32'h300, 5);
    @(posedge clk); #1;
    push_word(32'h305);
    @(negedge clk);
    chk("t3_done_drop", 32'(done), 32'd0);
    @(posedge clk); #1;
    wait_beats(wb + 6, "t3_beats");
    wait_done("t3_done2");
    chk_burst("t3_b1", bb + 1, 32'h14, 8'd0);
    chk_data("t3_tail", wb + 5, 32'h305, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t3_done_hold", 32'(done), 32'd1);
    @(negedge clk);
    chk("t3_done_en_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;

    // 4: grant withheld, FIFO fills to 64, then drains in four bursts
    gnt_en = 1'b0;
    restart(32'h0000_3000);
    bb = b_addr.size(); wb = w_data.size();
    push_n(64, 32'h400);
    @(negedge clk);
    chk("t4_ready_full", 32'(stream_ready), 32'd0);
    chk("t4_req_held", 32'(mem_req), 32'd1);
    chk("t4_req_addr", mem_addr, 32'h3000);
    chk("t4_req_len", 32'(mem_len), 32'd15);
    @(posedge clk); #1;
    stream_data  = 32'hDEAD_BEEF;
    stream_valid = 1'b1;
    tick(3);
    stream_valid = 1'b0;
    gnt_en = 1'b1;
    wait_beats(wb + 64, "t4_beats");
    tick(6);
    chk("t4_nburst", 32'(b_addr.size() - bb), 32'd4);
    chk_burst("t4_b0", bb, 32'h3000, 8'd15);
    chk_burst("t4_b1", bb + 1, 32'h3040, 8'd15);
    chk_burst("t4_b2", bb + 2, 32'h3080, 8'd15);
    chk_burst("t4_b3", bb + 3, 32'h30C0, 8'd15);
    chk_data("t4", wb, 32'h400, 64);
    chk("t4_no_extra", 32'(w_data.size()), 32'(wb + 64));

    // 5: random wready stalls with concurrent push/pop
    stall_en = 1'b1;
    restart(32'h0000_4000);
    bb = b_addr.size(); wb = w_data.size();
    push_n(48, 32'h500);
    wait_beats(wb + 48, "t5_beats");
    tick(6);
    stall_en = 1'b0;
    chk("t5_stable", 32'(stab_bad), 32'd0);
    chk("t5_nburst", 32'(b_addr.size() - bb), 32'd3);
    chk_burst("t5_b0", bb, 32'h4000, 8'd15);
    chk_burst("t5_b2", bb + 2, 32'h4080, 8'd15);
    chk_data("t5", wb, 32'h500, 48);

    // 6: reset in the middle of a data burst
    restart(32'h0000_5000);
    wb = w_data.size();
    push_n(16, 32'h600);
    begin
      int t = 0;
      while (w_data.size() < wb + 6 && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("t6_reached_beat", 32'(w_data.size() >= wb + 6), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_wvalid", 32'(mem_wvalid), 32'd0);
    chk("t6_wlast", 32'(mem_wlast), 32'd0);
    chk("t6_wdata", mem_wdata, 32'd0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_len", 32'(mem_len), 32'd0);
    chk("t6_ready", 32'(stream_ready), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b1;
    tick(5);
    @(negedge clk);
    chk("t6_empty_no_req", 32'(mem_req), 32'd0);
    chk("t6_empty_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
